// File: rtl/alu_pkg.sv
// Shared ALU/writeback definitions: opcodes, functs, flag bits, field slices.
// Imported by the ALU and by the writeback stage.
package alu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 2;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;
  localparam int FN_HI  = 5;
  localparam int FN_LO  = 0;

  // Only the instruction fields the writeback stage consumes.
  typedef struct packed {
    logic       valid;
    logic [5:0] opc;
    logic [4:0] rt;
    logic [15:0] imm;
    logic       z;
    logic       v;
  } wb_s_t;

  function automatic logic [31:0] br_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/regfile_32x32.sv
// Architectural register file: two async read ports, one write port.
// Register 0 is never written and always reads zero.
module regfile_32x32 #(
  parameter int NREGS = 32,
  parameter int XLEN  = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr_a,
  input  logic [AW-1:0]   raddr_b,
  output logic [XLEN-1:0] rdata_a,
  output logic [XLEN-1:0] rdata_b
);

  logic [XLEN-1:0] mem [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == '0) ? '0 : mem[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : mem[raddr_b];

endmodule

// File: rtl/alu_writeback.sv
// Writeback stage after the ALU: captures one result, decodes it,
// commits to the register file and resolves branches and overflow traps.
module alu_writeback
  import alu_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int XLEN  = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            hold,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] result,
  input  logic [2:0]      flags,
  input  logic [AW-1:0]   rd_addr_a,
  input  logic [AW-1:0]   rd_addr_b,
  output logic [XLEN-1:0] reg_a,
  output logic [XLEN-1:0] reg_b,
  output logic            wb_en,
  output logic [AW-1:0]   wb_addr,
  output logic [XLEN-1:0] wb_data,
  output logic            branch_taken,
  output logic [31:0]     branch_offset,
  output logic            mem_valid,
  output logic [XLEN-1:0] mem_addr,
  output logic            ovf_exc,
  output logic [7:0]      ovf_count
);

  wb_s_t           s;
  logic [XLEN-1:0] s_result;
  logic            acc;

  logic [AW-1:0]   dst;
  logic            wr;
  logic            trp;
  logic            brop;
  logic            br;
  logic            mv;
  logic [XLEN-1:0] rf_a;
  logic [XLEN-1:0] rf_b;

  logic unused_ok;
  assign unused_ok = &{1'b0, flags[FLAG_N], instruction[RS_HI:RS_LO]};

  assign in_ready = rst_n && !hold;
  assign acc      = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s        <= '0;
      s_result <= '0;
    end else begin
      s.valid <= acc;
      if (acc) begin
        s.opc    <= instruction[OPC_HI:OPC_LO];
        s.rt     <= instruction[RT_HI:RT_LO];
        s.imm    <= instruction[IMM_HI:IMM_LO];
        s.z      <= flags[FLAG_Z];
        s.v      <= flags[FLAG_V];
        s_result <= result;
      end
    end
  end

  always_comb begin
    dst  = '0;
    wr   = 1'b0;
    trp  = 1'b0;
    brop = 1'b0;
    br   = 1'b0;
    mv   = 1'b0;
    if (s.valid) begin
      unique case (1'b1)
        s.opc == OP_RTYPE: begin
          dst = s.imm[RD_HI:RD_LO];
          wr  = 1'b1;
          trp = (s.imm[FN_HI:FN_LO] == FN_ADD) ||
                (s.imm[FN_HI:FN_LO] == FN_SUB);
        end
        (s.opc >= OP_ADDI) && (s.opc <= OP_LUI): begin
          dst = s.rt;
          wr  = 1'b1;
          trp = (s.opc == OP_ADDI);
        end
        s.opc == OP_BEQ: begin
          brop = 1'b1;
          br   = s.z;
        end
        s.opc == OP_BNE: begin
          brop = 1'b1;
          br   = !s.z;
        end
        (s.opc == OP_LW) || (s.opc == OP_SW): mv = 1'b1;
        default: ;
      endcase
    end
  end

  assign ovf_exc       = trp && s.v;
  assign wb_en         = wr && !ovf_exc && (dst != '0);
  assign wb_addr       = wb_en ? dst : '0;
  assign wb_data       = wb_en ? s_result : '0;
  assign branch_taken  = br;
  assign branch_offset = brop ? br_offset(s.imm) : '0;
  assign mem_valid     = mv;
  assign mem_addr      = mv ? s_result : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_count <= '0;
    end else if (ovf_exc && (ovf_count != 8'hFF)) begin
      ovf_count <= ovf_count + 8'd1;
    end
  end

  regfile_32x32 #(
    .NREGS (NREGS),
    .XLEN  (XLEN)
  ) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wb_en),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (rd_addr_a),
    .raddr_b (rd_addr_b),
    .rdata_a (rf_a),
    .rdata_b (rf_b)
  );

  // Pending write is visible to the next ALU op before it commits.
  assign reg_a = (wb_en && (rd_addr_a == wb_addr) && (rd_addr_a != '0))
               ? wb_data : rf_a;
  assign reg_b = (wb_en && (rd_addr_b == wb_addr) && (rd_addr_b != '0))
               ? wb_data : rf_b;

endmodule
